// File: rtl/counter_ctrl.sv
// Run/hold/done counter controller: counts up or down to a latched limit, then
// either stops (one-shot, pulses o_done) or reloads (auto-reload, pulses o_wrap).
module counter_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_tick,
  input  logic             i_up_dn,
  input  logic             i_auto_reload,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_up;
  logic             r_auto;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  logic [WIDTH-1:0] w_start_val;
  logic [WIDTH-1:0] w_terminal;
  logic             w_at_term;
  logic             w_can_start;

  assign w_start_val = r_up ? '0 : r_limit;
  assign w_terminal  = r_up ? r_limit : '0;
  assign w_at_term   = (r_count == w_terminal);
  // start is only honoured when no run is in progress
  assign w_can_start = (r_state == StIdle) || (r_state == StDone);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_count <= '0;
      r_limit <= '0;
      r_up    <= 1'b0;
      r_auto  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      if (i_stop) begin
        r_state <= StIdle;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else if (i_start && w_can_start) begin
        r_limit <= i_limit;
        r_up    <= i_up_dn;
        r_auto  <= i_auto_reload;
        r_count <= i_up_dn ? '0 : i_limit;
        r_state <= StRun;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          StRun: begin
            if (i_pause) begin
              r_state <= StHold;
            end else if (i_tick) begin
              if (!w_at_term) begin
                r_count <= r_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
              end else if (r_auto) begin
                r_count <= w_start_val;
                r_wrap  <= 1'b1;
              end else begin
                r_state <= StDone;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          StHold: begin
            if (!i_pause) r_state <= StRun;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_count = r_count;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_wrap  = r_wrap;
  assign o_state = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random stimulus, all outputs
// compared every cycle against a behavioural model of the run/hold/done rules.
module tb_counter_ctrl;

  localparam int unsigned W = 4;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_start = 1'b0, i_stop = 1'b0, i_pause = 1'b0, i_tick = 1'b0;
  logic         i_up_dn = 1'b0, i_auto_reload = 1'b0;
  logic [W-1:0] i_limit = '0;
  logic [W-1:0] o_count;
  logic         o_busy, o_done, o_wrap;
  logic [1:0]   o_state;

  int n_checks = 0;
  int n_fail   = 0;

  counter_ctrl #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_pause      (i_pause),
    .i_tick       (i_tick),
    .i_up_dn      (i_up_dn),
    .i_auto_reload(i_auto_reload),
    .i_limit      (i_limit),
    .o_count      (o_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_wrap       (o_wrap),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural model: a run is "active" (busy) and may be "held"; "finished"
  // marks a completed one-shot run still showing its terminal count.
  bit     m_active, m_held, m_finished, m_up, m_auto, m_done, m_wrap;
  int     m_count, m_lim;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    m_active = 0; m_held = 0; m_finished = 0; m_up = 0; m_auto = 0;
    m_done = 0; m_wrap = 0; m_count = 0; m_lim = 0;
  endfunction

  function automatic void mdl_step(bit st, bit sp, bit pa, bit tk, bit ud, bit ar, int lm);
    int first, last;
    m_done = 0;
    m_wrap = 0;
    if (sp) begin
      m_active = 0; m_held = 0; m_finished = 0; m_count = 0;
    end else if (st && !m_active) begin
      m_up = ud; m_auto = ar; m_lim = lm;
      m_count = ud ? 0 : lm;
      m_active = 1; m_finished = 0;
    end else if (m_active && m_held) begin
      if (!pa) m_held = 0;
    end else if (m_active) begin
      first = m_up ? 0 : m_lim;
      last  = m_up ? m_lim : 0;
      if (pa) m_held = 1;
      else if (tk) begin
        if (m_count != last) m_count = (m_count + (m_up ? 1 : -1)) & ((1 << W) - 1);
        else if (m_auto) begin
          m_count = first; m_wrap = 1;
        end else begin
          m_active = 0; m_finished = 1; m_done = 1;
        end
      end
    end
  endfunction

  function automatic int mdl_state();
    if (!m_active) return m_finished ? 3 : 0;
    return m_held ? 2 : 1;
  endfunction

  task automatic check_all();
    chk("count", 32'(o_count), 32'(m_count));
    chk("state", 32'(o_state), 32'(mdl_state()));
    chk("busy",  32'(o_busy),  32'(m_active));
    chk("done",  32'(o_done),  32'(m_done));
    chk("wrap",  32'(o_wrap),  32'(m_wrap));
    if (m_active || m_finished) chk("in_range", 32'(o_count <= W'(m_lim)), 32'd1);
  endtask

  // One clock: drive inputs, advance model at the edge, compare at negedge.
  task automatic cyc(input bit st, sp, pa, tk, ud, ar, input int lm);
    i_start = st; i_stop = sp; i_pause = pa; i_tick = tk;
    i_up_dn = ud; i_auto_reload = ar; i_limit = W'(lm);
    @(posedge i_clk);
    mdl_step(st, sp, pa, tk, ud, ar, lm);
    @(negedge i_clk);
    check_all();
  endtask

  initial begin
    mdl_reset();
    #1;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    check_all();

    // Up one-shot to 5
    cyc(1, 0, 0, 1, 1, 0, 5);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 1, 9);
    chk("oneshot_done_count", 32'(o_count), 32'd5);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("oneshot_hold_state", 32'(o_state), 32'd3);

    // Down auto-reload from 3
    cyc(1, 0, 0, 1, 0, 1, 3);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1, 0, 12);
    chk("reload_busy", 32'(o_busy), 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Pause at 4 for 3 cycles, then resume
    cyc(1, 0, 0, 0, 1, 0, 9);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0, 9);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 0, 9);
    chk("pause_count", 32'(o_count), 32'd4);
    chk("pause_state", 32'(o_state), 32'd2);
    cyc(0, 0, 0, 1, 1, 0, 9);
    cyc(0, 0, 0, 1, 1, 0, 9);
    chk("resume_count", 32'(o_count), 32'd5);

    // Stop+start at count 7 wins stop; start+pause from idle runs
    cyc(0, 0, 0, 1, 1, 0, 9);
    cyc(0, 0, 0, 1, 1, 0, 9);
    chk("pre_stop_count", 32'(o_count), 32'd7);
    cyc(1, 1, 0, 1, 1, 0, 9);
    chk("stop_start_state", 32'(o_state), 32'd0);
    cyc(1, 0, 1, 1, 1, 0, 9);
    chk("start_pause_state", 32'(o_state), 32'd1);
    chk("start_pause_count", 32'(o_count), 32'd0);

    // Async reset mid-run at count 6
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 15);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1, 0, 15);
    chk("pre_reset_count", 32'(o_count), 32'd6);
    #2 i_reset = 1'b1;
    #1;
    chk("async_count", 32'(o_count), 32'd0);
    chk("async_busy",  32'(o_busy),  32'd0);
    chk("async_state", 32'(o_state), 32'd0);
    mdl_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0, 15);

    // limit=0 one-shot, then limit=15 up auto-reload wrapping 15->0
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    chk("lim0_done", 32'(o_done), 32'd1);
    cyc(1, 0, 0, 1, 1, 1, 15);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0, 0, 3);
    chk("lim15_wrap", 32'(o_wrap), 32'd1);
    chk("lim15_count", 32'(o_count), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0,
          1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter and limit width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request a count run (level, sampled per cycle).
REQ-005 stop  input  1  SHALL abort any run and return to idle.
REQ-006 pause  input  1  SHALL hold the count while high during a run.
REQ-007 tick  input  1  SHALL be the count-enable strobe; one step per cycle with tick=1.
REQ-008 up_dn  input  1  SHALL select direction (1 = up, 0 = down); sampled at start only.
REQ-009 auto_reload  input  1  SHALL select wrap (1) or one-shot (0); sampled at start only.
REQ-010 limit  input  WIDTH  SHALL give the terminal value; sampled at start only.
REQ-011 count  output  WIDTH  SHALL present the current count.
REQ-012 busy  output  1  SHALL be high in RUN or HOLD.
REQ-013 done  output  1  SHALL pulse one cycle when a one-shot run completes.
REQ-014 wrap  output  1  SHALL pulse one cycle on each auto-reload wrap.
REQ-015 state  output  2  SHALL encode IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-016 Input priority each cycle SHALL be stop > start > pause > tick.
REQ-017 On start in IDLE or DONE: latch up_dn, auto_reload, limit; load count with start value (0 if up, limit if down); go RUN next cycle.
REQ-018 start while in RUN or HOLD SHALL be ignored.
REQ-019 RUN, tick=1, count != terminal (limit if up, 0 if down): count SHALL step by +1 (up) or -1 (down) that cycle.
REQ-020 RUN, tick=1, count == terminal, auto_reload=1: count SHALL reload to start value, wrap SHALL pulse next cycle, state remains RUN.
REQ-021 RUN, tick=1, count == terminal, auto_reload=0: count SHALL hold terminal, state SHALL go DONE, done SHALL pulse next cycle.
REQ-022 RUN, pause=1: go HOLD; tick ignored in that cycle; count unchanged.
REQ-023 HOLD: count frozen; tick ignored; pause=0 returns to RUN next cycle.
REQ-024 stop=1 in any state: state IDLE, count 0, done/wrap low next cycle.
REQ-025 DONE: count holds terminal; busy low; remains until start or stop.
REQ-026 limit=0: terminal equals start value; first tick in RUN SHALL trigger terminal handling (one-shot DONE or wrap every tick).
REQ-027 Changes to limit, up_dn, auto_reload during RUN/HOLD SHALL have no effect until next start.
REQ-028 Count arithmetic SHALL be modulo 2^WIDTH; no value outside [0, latched limit] SHALL appear on count.
REQ-029 done and wrap SHALL never be high in the same cycle and SHALL be registered outputs.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, count 0, busy 0, done 0, wrap 0, and clear latched limit/direction/mode.
REQ-031 reset asserted mid-run SHALL abort the run; no done or wrap pulse SHALL follow deassertion.
REQ-032 After reset deassertion the block SHALL accept start on the first rising clk edge.

Verification
REQ-033 Up one-shot: limit=5, up_dn=1, auto_reload=0, start, tick every cycle -> count 0,1,2,3,4,5, then DONE with done pulse one cycle, count holds 5.
REQ-034 Down auto-reload: limit=3, up_dn=0, auto_reload=1, tick continuous -> count 3,2,1,0,3,2..., wrap pulse after each 0->3 reload, busy stays 1.
REQ-035 Pause/resume: limit=9 up, pause at count=4 for 3 cycles with tick=1 -> count stays 4, state HOLD; resumes 5 after pause drops.
REQ-036 Priority: stop and start together in RUN at count=7 -> IDLE, count 0; start+pause from IDLE -> RUN, count 0.
REQ-037 Async reset mid-run: limit=15 up, assert reset at count=6 between clk edges -> outputs 0 immediately, no done/wrap afterwards.
REQ-038 Boundary: limit=0 one-shot -> DONE after first tick with count 0; limit=15 (WIDTH=4) auto-reload up -> 15 wraps to 0 with wrap pulse.
